// File: rtl/counter_sweep_ctrl_if.sv
// Control/status bundle between the sweep sequencer, its config registers and the counter datapath.
// The master side owns config, handshake and the counter feedback; the slave side is the sequencer.
interface counter_sweep_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 4
);
    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         cycles;
    logic [WIDTH-1:0]   count;
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_ld_val;
    logic               cnt_en;
    logic               mode;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, lo, hi, dwell, cycles, count,
        input  cnt_load, cnt_ld_val, cnt_en, mode, busy, done, err
    );

    modport slave (
        input  start, abort, lo, hi, dwell, cycles, count,
        output cnt_load, cnt_ld_val, cnt_en, mode, busy, done, err
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the up/down counter: loads lo, counts up to hi and back down,
// dwelling at each end, for a programmed number of round trips.
module counter_sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_sweep_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DWELL_HI,
        DOWN,
        DWELL_LO,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [7:0]         cycles_q;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_next;
    logic [7:0]         sweep_cnt, sweep_cnt_next;
    logic               err_q, err_next;
    logic               latch_cfg;
    logic               cfg_bad;
    logic               out_of_range;
    logic               dwell_last;
    logic               cnt_load_c;
    logic               cnt_en_c;
    logic               mode_c;
    logic               done_c;

    assign cfg_bad      = (bus.lo >= bus.hi);
    assign out_of_range = (bus.count < lo_q) || (bus.count > hi_q);
    // A programmed dwell of zero still holds the end point for one cycle.
    assign dwell_last   = (dwell_q == '0) || (dwell_cnt == dwell_q - DWELL_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q      <= '0;
            hi_q      <= '0;
            dwell_q   <= '0;
            cycles_q  <= '0;
            dwell_cnt <= '0;
            sweep_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (latch_cfg) begin
                lo_q     <= bus.lo;
                hi_q     <= bus.hi;
                dwell_q  <= bus.dwell;
                cycles_q <= bus.cycles;
            end
            dwell_cnt <= latch_cfg ? '0 : dwell_cnt_next;
            sweep_cnt <= latch_cfg ? '0 : sweep_cnt_next;
            err_q     <= err_next;
        end
    end

    // Counter controls are Mealy on count so the counter stops exactly on a bound.
    always_comb begin
        state_next     = state;
        dwell_cnt_next = dwell_cnt;
        sweep_cnt_next = sweep_cnt;
        err_next       = 1'b0;
        latch_cfg      = 1'b0;
        cnt_load_c     = 1'b0;
        cnt_en_c       = 1'b0;
        mode_c         = 1'b0;
        done_c         = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (cfg_bad) begin
                        err_next = 1'b1;
                    end else begin
                        latch_cfg  = 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_load_c = 1'b1;
                state_next = UP;
            end
            UP: begin
                if (out_of_range) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (bus.count != hi_q) begin
                    cnt_en_c = 1'b1;
                end else begin
                    dwell_cnt_next = '0;
                    state_next     = DWELL_HI;
                end
            end
            DWELL_HI: begin
                if (dwell_last) begin
                    dwell_cnt_next = '0;
                    state_next     = DOWN;
                end else begin
                    dwell_cnt_next = dwell_cnt + DWELL_W'(1);
                end
            end
            DOWN: begin
                if (out_of_range) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (bus.count != lo_q) begin
                    cnt_en_c = 1'b1;
                    mode_c   = 1'b1;
                end else begin
                    // With cycles=0 the trip counter simply wraps and the sweep never ends.
                    sweep_cnt_next = sweep_cnt + 8'd1;
                    if ((cycles_q != 8'd0) && (sweep_cnt_next == cycles_q)) begin
                        state_next = DONE;
                    end else begin
                        dwell_cnt_next = '0;
                        state_next     = DWELL_LO;
                    end
                end
            end
            DWELL_LO: begin
                if (dwell_last) begin
                    dwell_cnt_next = '0;
                    state_next     = UP;
                end else begin
                    dwell_cnt_next = dwell_cnt + DWELL_W'(1);
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over every other outcome of the cycle, including done and range errors.
        if (bus.abort && (state != IDLE)) begin
            state_next     = IDLE;
            cnt_load_c     = 1'b0;
            cnt_en_c       = 1'b0;
            mode_c         = 1'b0;
            done_c         = 1'b0;
            err_next       = 1'b0;
            dwell_cnt_next = '0;
            sweep_cnt_next = sweep_cnt;
        end
    end

    assign bus.cnt_load   = cnt_load_c;
    assign bus.cnt_ld_val = lo_q;
    assign bus.cnt_en     = cnt_en_c;
    assign bus.mode       = mode_c;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_c;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a behavioural up/down counter closes the loop, a vector table
// covers complete sweeps and config errors, and directed sequences cover abort, range error and reset.
module tb_counter_sweep_ctrl;
    localparam int WIDTH   = 8;
    localparam int DWELL_W = 4;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] dwell;
        logic [7:0] cycles;
        logic       expErr;
        int         expLatency;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [WIDTH-1:0] cntModel;
    logic forceEn = 1'b0;
    logic [WIDTH-1:0] forceVal = '0;
    int checks = 0;
    int failures = 0;
    vec_t vecs[9];

    counter_sweep_ctrl_if #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) bus ();

    counter_sweep_ctrl #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the counter datapath; forceEn lets a sequence inject a bogus count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntModel <= '0;
        end else if (bus.cnt_load) begin
            cntModel <= bus.cnt_ld_val;
        end else if (bus.cnt_en) begin
            cntModel <= bus.mode ? cntModel - 8'd1 : cntModel + 8'd1;
        end
    end

    assign bus.count = forceEn ? forceVal : cntModel;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.lo     = v.lo;
        bus.hi     = v.hi;
        bus.dwell  = v.dwell;
        bus.cycles = v.cycles;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
    endtask

    task automatic runSweep(input vec_t v, input int idx);
        int latency;
        int loads;
        int errSeen;
        int rangeBad;
        int peak;
        latency  = -1;
        errSeen  = 0;
        rangeBad = 0;
        peak     = int'(v.lo);
        applyStimulus(v);
        if (v.expErr) begin
            checkOutput($sformatf("row%0d_err", idx), int'(bus.err), 1);
            checkOutput($sformatf("row%0d_busy", idx), int'(bus.busy), 0);
            checkOutput($sformatf("row%0d_ctl", idx), int'({bus.cnt_load, bus.cnt_en}), 0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d_err_clear", idx),
                        int'({bus.err, bus.busy, bus.cnt_load, bus.cnt_en}), 0);
            return;
        end
        loads = int'(bus.cnt_load);
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            // Start and config changes while busy must be ignored.
            if (n == 3) begin
                bus.start  = 1'b1;
                bus.lo     = ~v.lo;
                bus.hi     = v.lo;
                bus.dwell  = ~v.dwell;
                bus.cycles = v.cycles + 8'd5;
            end
            if (n == 4) bus.start = 1'b0;
            loads   += int'(bus.cnt_load);
            errSeen += int'(bus.err);
            if ((bus.count < v.lo) || (bus.count > v.hi)) rangeBad = 1;
            if (int'(bus.count) > peak) peak = int'(bus.count);
            if (bus.done) begin
                latency = n;
                if (bus.count != v.lo) rangeBad = 1;
                break;
            end
        end
        checkOutput($sformatf("row%0d_latency", idx), latency, v.expLatency);
        checkOutput($sformatf("row%0d_loads", idx), loads, 1);
        checkOutput($sformatf("row%0d_no_err", idx), errSeen, 0);
        checkOutput($sformatf("row%0d_range_bad", idx), rangeBad, 0);
        checkOutput($sformatf("row%0d_peak", idx), peak, int'(v.hi));
        @(posedge clk);
        #1;
        checkOutput($sformatf("row%0d_after_done", idx), int'({bus.busy, bus.done}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int downs;
        int prevDown;
        vec_t v;

        vecs[0] = '{8'd10,  8'd13,  4'd2,  8'd1, 1'b0, 11};
        vecs[1] = '{8'd20,  8'd20,  4'd0,  8'd1, 1'b1, 0};
        vecs[2] = '{8'd0,   8'd255, 4'd0,  8'd2, 1'b0, 1028};
        vecs[3] = '{8'd200, 8'd100, 4'd3,  8'd1, 1'b1, 0};
        vecs[4] = '{8'd5,   8'd6,   4'd0,  8'd3, 1'b0, 18};
        vecs[5] = '{8'd3,   8'd7,   4'd5,  8'd2, 1'b0, 36};
        vecs[6] = '{8'd250, 8'd255, 4'd15, 8'd1, 1'b0, 28};
        vecs[7] = '{8'd0,   8'd1,   4'd1,  8'd1, 1'b0, 6};
        vecs[8] = '{8'd0,   8'd0,   4'd0,  8'd0, 1'b1, 0};

        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.lo     = '0;
        bus.hi     = '0;
        bus.dwell  = '0;
        bus.cycles = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    int'({bus.busy, bus.cnt_load, bus.cnt_en, bus.mode, bus.done, bus.err, bus.cnt_ld_val}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            runSweep(vecs[i], i);
        end

        // Endless sweep (cycles=0) aborted on entry to the third DOWN phase.
        v = '{8'd5, 8'd8, 4'd1, 8'd0, 1'b0, 0};
        applyStimulus(v);
        downs    = 0;
        prevDown = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.cnt_en && bus.mode && (prevDown == 0)) downs++;
            prevDown = int'(bus.cnt_en && bus.mode);
            if (downs == 3) break;
        end
        checkOutput("abort_third_down_reached", downs, 3);
        bus.abort = 1'b1;
        #1;
        checkOutput("abort_same_cycle_en", int'(bus.cnt_en), 0);
        checkOutput("abort_same_cycle_busy", int'(bus.busy), 1);
        checkOutput("abort_same_cycle_done_err", int'({bus.done, bus.err}), 0);
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        checkOutput("abort_idle", int'({bus.busy, bus.done, bus.err, bus.cnt_en}), 0);
        @(posedge clk);
        #1;
        checkOutput("abort_no_late_err", int'({bus.busy, bus.done, bus.err}), 0);

        // Counter forced outside the range during UP.
        v = '{8'd10, 8'd50, 4'd1, 8'd1, 1'b0, 0};
        applyStimulus(v);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("range_pre_count", int'(bus.count), 11);
        forceVal = 8'd200;
        forceEn  = 1'b1;
        #1;
        checkOutput("range_en_dropped", int'(bus.cnt_en), 0);
        @(posedge clk);
        #1;
        checkOutput("range_err_pulse", int'(bus.err), 1);
        checkOutput("range_idle", int'({bus.busy, bus.cnt_en, bus.done}), 0);
        forceEn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("range_err_one_cycle", int'({bus.err, bus.busy}), 0);

        // Reset pulled mid-DWELL_HI, then a clean rerun.
        v = '{8'd10, 8'd12, 4'd8, 8'd1, 1'b0, 0};
        applyStimulus(v);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("dwell_hi_hold", int'({bus.busy, bus.cnt_en, bus.cnt_load}), 3'b100);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_outputs",
                    int'({bus.busy, bus.cnt_load, bus.cnt_en, bus.mode, bus.done, bus.err, bus.cnt_ld_val}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runSweep(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
